// File: rtl/s2_pkg.sv
`default_nettype none
// ============================================================================
// Module : s2_pkg
// Brief  : Shared state type and tile/filter geometry for the stage-2 sequencer.
// Rev    : 1.0
// ============================================================================
package s2_pkg;

    localparam int S2_ROWS    = 8;
    localparam int S2_COLS    = 8;
    localparam int S2_CHANS   = 3;
    localparam int S2_K       = 3;
    localparam int S2_NFILT   = 4;
    localparam int S2_OUT_DIM = S2_ROWS - S2_K + 1;
    localparam int S2_NPIX    = S2_ROWS * S2_COLS * S2_CHANS;
    localparam int S2_NOUT    = S2_NFILT * S2_OUT_DIM * S2_OUT_DIM;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        PROC  = 3'd3,
        DONE  = 3'd4
    } s2_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/s2_addr_delay.sv
`default_nettype none
// ============================================================================
// Module : s2_addr_delay
// Brief  : RD_LAT-deep shift register aligning read strobe/coords with BRAM data.
// Rev    : 1.0
// ============================================================================
module s2_addr_delay #(
    parameter int RD_LAT = 1,
    parameter int W      = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_d,
    output logic [W-1:0] out_q
);

    logic [RD_LAT-1:0][W-1:0] pipe_q;
    logic [RD_LAT-1:0][W-1:0] pipe_d;

    generate
        if (RD_LAT == 1) begin : g_single
            always_comb pipe_d = in_d;
        end else begin : g_multi
            always_comb pipe_d = {pipe_q[RD_LAT-2:0], in_d};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_q = pipe_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/s2_sequencer.sv
`default_nettype none
// ============================================================================
// Module : s2_sequencer
// Brief  : Loads one 8x8x3 tile from BRAM, then steps filter x position index
//          with a valid/ready handshake towards the FC stage.
// Rev    : 1.0
// ============================================================================
module s2_sequencer
    import s2_pkg::*;
#(
    parameter int ROWS   = S2_ROWS,
    parameter int COLS   = S2_COLS,
    parameter int CHANS  = S2_CHANS,
    parameter int K      = S2_K,
    parameter int NFILT  = S2_NFILT,
    parameter int ADDR_W = $clog2(S2_NPIX),
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_done,
    input  logic              out_ready,
    output logic              busy,
    output logic              enable_read,
    output logic [ADDR_W-1:0] read_addr,
    output logic              wr_en,
    output logic [2:0]        row_addr,
    output logic [2:0]        col_addr,
    output logic [1:0]        cha_addr,
    output logic              data_rdy,
    output logic [1:0]        proc_dir,
    output logic [5:0]        proc_counter,
    output logic              out_valid,
    output logic              done
);

    localparam int         OUT_DIM    = ROWS - K + 1;
    localparam logic [2:0] ROW_LAST   = 3'(ROWS - 1);
    localparam logic [2:0] COL_LAST   = 3'(COLS - 1);
    localparam logic [1:0] CHA_LAST   = 2'(CHANS - 1);
    localparam logic [1:0] DIR_LAST   = 2'(NFILT - 1);
    localparam logic [5:0] CNT_LAST   = 6'(OUT_DIM * OUT_DIM - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    s2_seq_state_t     state_q, state_d;
    logic [2:0]        row_q, row_d, col_q, col_d;
    logic [1:0]        cha_q, cha_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic              enable_read_q, enable_read_d;
    logic [1:0]        drain_q, drain_d;
    logic              data_rdy_q, data_rdy_d;
    logic [1:0]        proc_dir_q, proc_dir_d;
    logic [5:0]        proc_counter_q, proc_counter_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              pending_q, pending_d;

    logic load_last, drain_last, accept, proc_last, load_start, proc_start;
    logic [8:0] wr_bundle;

    assign load_last  = (cha_q == CHA_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign drain_last = (drain_q == DRAIN_LAST);
    assign accept     = out_valid_q && out_ready;
    assign proc_last  = (proc_dir_q == DIR_LAST) && (proc_counter_q == CNT_LAST);
    assign load_start = (state_d == LOAD) && (state_q != LOAD);
    assign proc_start = (state_q == DRAIN) && (state_d == PROC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            row_q          <= '0;
            col_q          <= '0;
            cha_q          <= '0;
            read_addr_q    <= '0;
            enable_read_q  <= 1'b0;
            drain_q        <= '0;
            data_rdy_q     <= 1'b0;
            proc_dir_q     <= '0;
            proc_counter_q <= '0;
            out_valid_q    <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            cha_q          <= cha_d;
            read_addr_q    <= read_addr_d;
            enable_read_q  <= enable_read_d;
            drain_q        <= drain_d;
            data_rdy_q     <= data_rdy_d;
            proc_dir_q     <= proc_dir_d;
            proc_counter_q <= proc_counter_d;
            out_valid_q    <= out_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            pending_q      <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (data_done) state_d = LOAD;
            LOAD:    if (load_last) state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = PROC;
            PROC:    if (accept && proc_last) state_d = DONE;
            DONE:    state_d = (pending_q || data_done) ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d          = row_q;
        col_d          = col_q;
        cha_d          = cha_q;
        read_addr_d    = read_addr_q;
        proc_dir_d     = proc_dir_q;
        proc_counter_d = proc_counter_q;

        // Column fastest, then row, then channel; counters park on the last word.
        if (load_start) begin
            row_d       = '0;
            col_d       = '0;
            cha_d       = '0;
            read_addr_d = '0;
        end else if ((state_q == LOAD) && !load_last) begin
            read_addr_d = read_addr_q + ADDR_W'(1);
            if (col_q != COL_LAST) begin
                col_d = col_q + 3'd1;
            end else begin
                col_d = '0;
                if (row_q != ROW_LAST) begin
                    row_d = row_q + 3'd1;
                end else begin
                    row_d = '0;
                    cha_d = cha_q + 2'd1;
                end
            end
        end

        // Index holds at the last result after completion until the next tile.
        if (proc_start) begin
            proc_dir_d     = '0;
            proc_counter_d = '0;
        end else if ((state_q == PROC) && accept && !proc_last) begin
            if (proc_counter_q != CNT_LAST) begin
                proc_counter_d = proc_counter_q + 6'd1;
            end else begin
                proc_counter_d = '0;
                proc_dir_d     = proc_dir_q + 2'd1;
            end
        end

        enable_read_d = (state_d == LOAD);
        drain_d       = (state_q == DRAIN) ? drain_q + 2'd1 : '0;
        data_rdy_d    = proc_start;
        out_valid_d   = (state_d == PROC);
        done_d        = (state_d == DONE);
        busy_d        = (state_d != IDLE);

        if (state_q == DONE) begin
            pending_d = 1'b0;
        end else if ((state_q != IDLE) && data_done) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    s2_addr_delay #(
        .RD_LAT (RD_LAT),
        .W      (9)
    ) u_addr_delay (
        .clk   (clk),
        .reset (reset),
        .in_d  ({enable_read_q, row_q, col_q, cha_q}),
        .out_q (wr_bundle)
    );

    assign {wr_en, row_addr, col_addr, cha_addr} = wr_bundle;

    assign busy         = busy_q;
    assign enable_read  = enable_read_q;
    assign read_addr    = read_addr_q;
    assign data_rdy     = data_rdy_q;
    assign proc_dir     = proc_dir_q;
    assign proc_counter = proc_counter_q;
    assign out_valid    = out_valid_q;
    assign done         = done_q;

endmodule
`default_nettype wire
